// File: rtl/eth_rx_slot_ctrl.sv
// 8-slot MAC receive buffer sequencer: 16-bit frame writes on port A, 64-bit AXI-Stream replay from port B.
// Optional RX_CRC_STRIP_EN: committed length excludes the 4-byte FCS; frames of raw length <= 4 are dropped.
module eth_rx_slot_ctrl #(
   parameter int SLOT_BITS = 3,
   parameter int HW_BITS   = 10,
   parameter int CNT_W     = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          rx_valid_i,
   input  logic [15:0]                   rx_data_i,
   input  logic                          rx_last_i,
   input  logic                          rx_odd_i,
   input  logic                          rx_err_i,
   output logic [SLOT_BITS+HW_BITS-1:0]  mem_addra_o,
   output logic [15:0]                   mem_dina_o,
   output logic [1:0]                    mem_wea_o,
   output logic                          mem_ena_o,
   output logic [SLOT_BITS+HW_BITS-3:0]  mem_addrb_o,
   output logic                          mem_enb_o,
   input  logic [63:0]                   mem_doutb_i,
   output logic [63:0]                   m_tdata_o,
   output logic [7:0]                    m_tkeep_o,
   output logic                          m_tlast_o,
   output logic                          m_tvalid_o,
   input  logic                          m_tready_i,
   output logic [SLOT_BITS:0]            frames_pending_o,
   output logic [CNT_W-1:0]              drop_cnt_o
);

   localparam int SLOTS   = 1 << SLOT_BITS;
   localparam int QW_BITS = HW_BITS - 2;
   localparam int LEN_W   = HW_BITS + 2;
   localparam int BEAT_W  = QW_BITS + 1;
   localparam logic [SLOT_BITS:0] PEND_FULL = (SLOT_BITS + 1)'(SLOTS);

   typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} w_state_t;
   typedef enum logic       {R_IDLE, R_READ} r_state_t;

   typedef struct packed {
      logic        last;
      logic [7:0]  keep;
      logic [63:0] data;
   } beat_t;

   w_state_t                 w_state, w_next;
   r_state_t                 r_state, r_next;
   logic [HW_BITS:0]         hw_cnt;
   logic [SLOT_BITS-1:0]     wr_slot, rd_slot;
   logic [SLOT_BITS:0]       pending;
   logic [CNT_W-1:0]         drop_cnt;
   logic [LEN_W-1:0]         len_mem [SLOTS];
   logic [LEN_W-1:0]         raw_len, commit_len, head_len;
   logic                     too_short, frame_end, wr_en, commit, drop_evt;
   logic [BEAT_W-1:0]        beats, issue_cnt, head_beats;
   logic [7:0]               last_keep, head_keep;
   logic [2:0]               len_mod;
   logic                     rd_issue, in_flight, in_flight_last;
   beat_t                    skid [2];
   logic                     sk_wp, sk_rp, push, pop, rel;
   logic [1:0]               occ;

   // ---------------- write side ----------------
   assign frame_end = rx_valid_i & rx_last_i;
   assign raw_len   = {1'b0, hw_cnt[HW_BITS-1:0], 1'b0} + (rx_odd_i ? LEN_W'(1) : LEN_W'(2));

`ifdef RX_CRC_STRIP_EN
   assign too_short  = raw_len <= LEN_W'(4);
   assign commit_len = raw_len - LEN_W'(4);
`else
   assign too_short  = 1'b0;
   assign commit_len = raw_len;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) w_state <= W_IDLE;
      else         w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (rx_valid_i) w_next = frame_end ? W_IDLE : (wr_en ? W_FRAME : W_DROP);
         W_FRAME: if (frame_end) w_next = W_IDLE;
                  else if (rx_valid_i && !wr_en) w_next = W_DROP;
         W_DROP:  if (frame_end) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_en    = 1'b0;
      commit   = 1'b0;
      drop_evt = 1'b0;
      unique case (w_state)
         W_IDLE:  wr_en = rx_valid_i && (pending != PEND_FULL);
         W_FRAME: wr_en = rx_valid_i && !hw_cnt[HW_BITS];
         default: wr_en = 1'b0;
      endcase
      if (frame_end) begin
         if (wr_en && !rx_err_i && !too_short) commit   = 1'b1;
         else                                  drop_evt = 1'b1;
      end
   end

   assign mem_ena_o   = wr_en;
   assign mem_wea_o   = {2{wr_en}};
   assign mem_addra_o = {wr_slot, hw_cnt[HW_BITS-1:0]};
   assign mem_dina_o  = rx_data_i;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hw_cnt   <= '0;
         wr_slot  <= '0;
         drop_cnt <= '0;
         pending  <= '0;
      end else begin
         if (frame_end)  hw_cnt <= '0;
         else if (wr_en) hw_cnt <= hw_cnt + (HW_BITS + 1)'(1);
         if (commit) wr_slot <= wr_slot + SLOT_BITS'(1);
         if (drop_evt && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
         if (commit && !rel)      pending <= pending + (SLOT_BITS + 1)'(1);
         else if (!commit && rel) pending <= pending - (SLOT_BITS + 1)'(1);
      end
   end

   // NOTE: the length table is not reset; a slot is only read after a commit has written it.
   always_ff @(posedge clk_i) begin
      if (commit) len_mem[wr_slot] <= commit_len;
   end

   assign frames_pending_o = pending;
   assign drop_cnt_o       = drop_cnt;

   // ---------------- read side ----------------
   assign head_len   = len_mem[rd_slot];
   assign len_mod    = head_len[2:0];
   assign head_beats = BEAT_W'((head_len + LEN_W'(7)) >> 3);
   assign head_keep  = (len_mod == 3'd0) ? 8'hFF : 8'hFF >> (4'd8 - {1'b0, len_mod});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= R_IDLE;
      else         r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (pending != '0) r_next = R_READ;
         R_READ:  if (rel) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Reads are only issued when the skid buffer can absorb every outstanding word.
   always_comb begin
      rd_issue = 1'b0;
      if (r_state == R_READ)
         rd_issue = (issue_cnt != beats) && ((occ + {1'b0, in_flight}) < 2'd2);
   end

   assign mem_enb_o   = rd_issue;
   assign mem_addrb_o = {rd_slot, issue_cnt[QW_BITS-1:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beats          <= '0;
         issue_cnt      <= '0;
         last_keep      <= '0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
         rd_slot        <= '0;
      end else begin
         if (r_state == R_IDLE && r_next == R_READ) begin
            beats     <= head_beats;
            last_keep <= head_keep;
            issue_cnt <= '0;
         end else if (rd_issue) begin
            issue_cnt <= issue_cnt + BEAT_W'(1);
         end
         in_flight      <= rd_issue;
         in_flight_last <= rd_issue && (issue_cnt == beats - BEAT_W'(1));
         if (rel) rd_slot <= rd_slot + SLOT_BITS'(1);
      end
   end

   // Two-entry skid FIFO holding RAM words until the stream accepts them.
   assign push = in_flight;
   assign pop  = m_tvalid_o && m_tready_i;
   assign rel  = pop && skid[sk_rp].last;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 2; i++) skid[i] <= '0;
         sk_wp <= 1'b0;
         sk_rp <= 1'b0;
         occ   <= '0;
      end else begin
         if (push) begin
            skid[sk_wp] <= '{last: in_flight_last,
                             keep: in_flight_last ? last_keep : 8'hFF,
                             data: mem_doutb_i};
            sk_wp <= ~sk_wp;
         end
         if (pop) sk_rp <= ~sk_rp;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   assign m_tvalid_o = (occ != 2'd0);
   assign m_tdata_o  = skid[sk_rp].data;
   assign m_tkeep_o  = skid[sk_rp].keep;
   assign m_tlast_o  = skid[sk_rp].last;

endmodule

// File: tb/tb_eth_rx_slot_ctrl.sv
// Directed bench for eth_rx_slot_ctrl (default build): RAM model on both ports, stream collector
// and protocol monitors, hand-derived expected beats.
module tb_eth_rx_slot_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid, rx_last, rx_odd, rx_err;
   logic [15:0] rx_data;
   logic [12:0] mem_addra;
   logic [15:0] mem_dina;
   logic [1:0]  mem_wea;
   logic        mem_ena;
   logic [10:0] mem_addrb;
   logic        mem_enb;
   logic [63:0] mem_doutb;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast, tvalid, tready;
   logic [3:0]  pending;
   logic [15:0] drop_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   int rdy_mode = 0;   // 0: ready low, 1: ready high, 2: toggle every cycle

   logic [72:0] beat_log [$];
   logic [12:0] wr_log [$];
   int          rd_i = 0;
   int          stab_err = 0, full_err = 0;

   always #5 clk = ~clk;

   eth_rx_slot_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n),
      .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_last_i(rx_last),
      .rx_odd_i(rx_odd), .rx_err_i(rx_err),
      .mem_addra_o(mem_addra), .mem_dina_o(mem_dina), .mem_wea_o(mem_wea), .mem_ena_o(mem_ena),
      .mem_addrb_o(mem_addrb), .mem_enb_o(mem_enb), .mem_doutb_i(mem_doutb),
      .m_tdata_o(tdata), .m_tkeep_o(tkeep), .m_tlast_o(tlast), .m_tvalid_o(tvalid),
      .m_tready_i(tready), .frames_pending_o(pending), .drop_cnt_o(drop_cnt)
   );

   // Asymmetric RAM model: 16-bit writes, 64-bit registered reads.
   logic [15:0] ram [8192];
   always @(posedge clk) begin
      if (mem_ena && mem_wea == 2'b11) ram[mem_addra] <= mem_dina;
      if (mem_enb) mem_doutb <= {ram[{mem_addrb, 2'd3}], ram[{mem_addrb, 2'd2}],
                                 ram[{mem_addrb, 2'd1}], ram[{mem_addrb, 2'd0}]};
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       tready = 1'b0;
         1:       tready = 1'b1;
         default: tready = ~tready;
      endcase
   end

   // Collectors and protocol monitors sample on the falling edge.
   logic        prev_stall = 1'b0, infl_m = 1'b0;
   logic [72:0] prev_beat = '0;
   int          occ_m = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
         occ_m      <= 0;
         infl_m     <= 1'b0;
      end else begin
         if (mem_ena) wr_log.push_back(mem_addra);
         if (tvalid && tready) beat_log.push_back({tlast, tkeep, tdata});
         if (prev_stall && (!tvalid || {tlast, tkeep, tdata} != prev_beat)) stab_err <= stab_err + 1;
         if (mem_enb && (occ_m + int'(infl_m)) >= 2) full_err <= full_err + 1;
         prev_stall <= tvalid && !tready;
         prev_beat  <= {tlast, tkeep, tdata};
         occ_m      <= occ_m + int'(infl_m) - int'(tvalid && tready);
         infl_m     <= mem_enb;
      end
   end

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      rx_valid = 1'b0; rx_last = 1'b0; rx_odd = 1'b0; rx_err = 1'b0; rx_data = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input int nhw, input logic [7:0] seed, input bit odd, input bit err,
                             input bit term);
      for (int i = 0; i < nhw; i++) begin
         rx_valid = 1'b1;
         rx_data  = {8'(seed + 2 * i + 1), 8'(seed + 2 * i)};
         rx_last  = term && (i == nhw - 1);
         rx_odd   = rx_last & odd;
         rx_err   = rx_last & err;
         @(posedge clk); #1;
      end
      rx_valid = 1'b0; rx_last = 1'b0; rx_odd = 1'b0; rx_err = 1'b0;
   endtask

   function automatic logic [72:0] exp_beat(input logic [7:0] seed, input int len, input int b);
      logic [72:0] r  = '0;
      int          nb = (len + 7) / 8;
      for (int j = 0; j < 8; j++)
         if (8 * b + j < len) begin
            r[8 * j +: 8] = 8'(seed + 8 * b + j);
            r[64 + j]     = 1'b1;
         end
      r[72] = (b == nb - 1);
      return r;
   endfunction

   task automatic wait_beats(input int n);
      int budget = 3000;
      while (beat_log.size() < rd_i + n && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      if (budget == 0) check("beat_timeout", 80'(beat_log.size()), 80'(rd_i + n));
   endtask

   task automatic check_frame(input string tag, input logic [7:0] seed, input int len);
      int          nb = (len + 7) / 8;
      logic [72:0] e, o;
      wait_beats(nb);
      for (int b = 0; b < nb; b++) begin
         e = exp_beat(seed, len, b);
         o = (rd_i < beat_log.size()) ? beat_log[rd_i] : '1;
         for (int j = 0; j < 8; j++) if (!e[64 + j]) o[8 * j +: 8] = 8'h00;
         check($sformatf("%s_beat%0d", tag, b), 80'(o), 80'(e));
         rd_i++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w0;
      rst_n = 1'b0;
      rx_valid = 1'b0; rx_last = 1'b0; rx_odd = 1'b0; rx_err = 1'b0; rx_data = '0;
      tready = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(1);

      // Reset state
      check("rst_tvalid",  80'(tvalid),  80'(0));
      check("rst_tdata",   80'({tlast, tkeep, tdata}), 80'(0));
      check("rst_pending", 80'(pending), 80'(0));
      check("rst_drop",    80'(drop_cnt), 80'(0));
      check("rst_mem_en",  80'({mem_ena, mem_wea, mem_enb}), 80'(0));

      // 64-byte frame into slot 0
      rdy_mode = 1;
      w0 = wr_log.size();
      send_frame(32, 8'h10, 1'b0, 1'b0, 1'b1);
      check("f64_writes",  80'(wr_log.size() - w0), 80'(32));
      check("f64_first",   80'(wr_log[w0]),      80'(0));
      check("f64_last",    80'(wr_log[w0 + 31]), 80'(31));
      check("f64_pend1",   80'(pending), 80'(1));
      check_frame("f64", 8'h10, 64);
      idle(3);
      check("f64_pend0",   80'(pending), 80'(0));

      // 61-byte odd frame into slot 1
      w0 = wr_log.size();
      send_frame(31, 8'h40, 1'b1, 1'b0, 1'b1);
      check("f61_first",   80'(wr_log[w0]), 80'(1024));
      check_frame("f61", 8'h40, 61);

      // single-halfword odd frame into slot 2: one byte
      w0 = wr_log.size();
      send_frame(1, 8'h77, 1'b1, 1'b0, 1'b1);
      check("f1_first",    80'(wr_log[w0]), 80'(2048));
      check_frame("f1", 8'h77, 1);
      idle(3);
      check("f1_pend0",    80'(pending), 80'(0));

      // Errored frame: no output, counted, slot reused
      do_reset();
      send_frame(20, 8'h20, 1'b0, 1'b1, 1'b1);
      idle(40);
      check("err_no_out",  80'(beat_log.size() - rd_i), 80'(0));
      check("err_drop",    80'(drop_cnt), 80'(1));
      check("err_pend",    80'(pending),  80'(0));
      w0 = wr_log.size();
      send_frame(16, 8'h30, 1'b0, 1'b0, 1'b1);
      check("err_next_slot", 80'(wr_log[w0]), 80'(0));
      check_frame("err_next", 8'h30, 32);

      // Nine 60-byte frames with the stream stalled: 8 held, 9th dropped
      do_reset();
      rdy_mode = 0;
      for (int f = 0; f < 9; f++) send_frame(30, 8'(f * 16 + 3), 1'b0, 1'b0, 1'b1);
      idle(2);
      check("full_pending", 80'(pending),  80'(8));
      check("full_drop",    80'(drop_cnt), 80'(1));
      check("full_no_out",  80'(beat_log.size() - rd_i), 80'(0));
      rdy_mode = 1;
      for (int f = 0; f < 8; f++) check_frame($sformatf("full_f%0d", f), 8'(f * 16 + 3), 60);
      idle(5);
      check("full_drained", 80'(pending), 80'(0));
      check("full_extra",   80'(beat_log.size() - rd_i), 80'(0));
      w0 = wr_log.size();
      send_frame(30, 8'hA0, 1'b0, 1'b0, 1'b1);
      check("full_wrap_slot", 80'(wr_log[w0]), 80'(0));
      check_frame("full_wrap", 8'hA0, 60);

      // Oversize frame: 1024 writes then silence, dropped, pointer kept
      do_reset();
      w0 = wr_log.size();
      send_frame(1100, 8'h05, 1'b0, 1'b0, 1'b1);
      check("ovs_writes", 80'(wr_log.size() - w0), 80'(1024));
      check("ovs_last",   80'(wr_log[w0 + 1023]), 80'(1023));
      check("ovs_drop",   80'(drop_cnt), 80'(1));
      idle(20);
      check("ovs_pend",   80'(pending), 80'(0));
      check("ovs_no_out", 80'(beat_log.size() - rd_i), 80'(0));
      w0 = wr_log.size();
      send_frame(4, 8'h11, 1'b0, 1'b0, 1'b1);
      check("ovs_next_slot", 80'(wr_log[w0]), 80'(0));
      check_frame("ovs_next", 8'h11, 8);

      // Reset in the middle of a frame: lost silently
      do_reset();
      send_frame(10, 8'h60, 1'b0, 1'b0, 1'b0);
      do_reset();
      check("mid_drop",   80'(drop_cnt), 80'(0));
      check("mid_pend",   80'(pending),  80'(0));
      w0 = wr_log.size();
      send_frame(8, 8'h68, 1'b0, 1'b0, 1'b1);
      check("mid_next_slot", 80'(wr_log[w0]), 80'(0));
      check_frame("mid_next", 8'h68, 16);

      // 128-byte frame with ready toggling every cycle
      rdy_mode = 2;
      send_frame(64, 8'hC0, 1'b0, 1'b0, 1'b1);
      check_frame("tog", 8'hC0, 128);
      rdy_mode = 1;
      idle(10);
      check("tog_extra", 80'(beat_log.size() - rd_i), 80'(0));
      check("tog_pend",  80'(pending), 80'(0));

      // Protocol monitors over the whole run
      check("hold_stable",    80'(stab_err), 80'(0));
      check("skid_full_read", 80'(full_err), 80'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_rx_slot_ctrl.md
Name: eth_rx_slot_ctrl

Overview:
- Single-clock controller that sequences an 8-slot asymmetric receive buffer (16-bit write port A, 64-bit read port B).
- Accepts a 16-bit MAC receive stream and writes each frame into a free 2 KB slot; errored, oversized or no-room frames are dropped.
- Replays committed frames in order as a 64-bit AXI-Stream with tkeep.
- Sits between the MAC RX path and the host DMA/AXI side.

Parameters:
- SLOT_BITS, 3: log2 slot count; 8 slots.
- HW_BITS, 10: log2 16-bit halfwords per slot; 1024 halfwords = 2048 bytes.
- CNT_W, 16: width of the drop counter.

Ports:
- clk_i  in  1  clock; also clocks both buffer ports.
- rst_ni  in  1  asynchronous active-low reset.
- rx_valid_i  in  1  halfword valid; no backpressure.
- rx_data_i  in  16  bits [7:0] = lower-address byte.
- rx_last_i  in  1  final halfword of the frame.
- rx_odd_i  in  1  qualified by rx_last_i; 1 = only [7:0] valid.
- rx_err_i  in  1  qualified by rx_last_i; frame bad.
- mem_addra_o  out  13  {slot, hw_idx}.
- mem_dina_o  out  16  write data.
- mem_wea_o  out  2  write strobes; 2'b11 on write.
- mem_ena_o  out  1  port A enable.
- mem_addrb_o  out  11  {slot, qw_idx[7:0]}.
- mem_enb_o  out  1  port B read enable.
- mem_doutb_i  in  64  read data, valid 1 cycle after mem_enb_o; halfword k in bits [16k+15:16k].
- m_tdata_o  out  64  stream data.
- m_tkeep_o  out  8  byte valid.
- m_tlast_o  out  1  final beat of the frame.
- m_tvalid_o  out  1  stream valid.
- m_tready_i  in  1  stream ready.
- frames_pending_o  out  4  committed frames not yet fully read (0..8).
- drop_cnt_o  out  CNT_W  dropped frames; saturates at all-ones.

Behaviour:
- Reset: all outputs 0; write and read slot pointers 0; pending count 0; skid buffer empty.
- Write FSM states: W_IDLE, W_FRAME, W_DROP.
- W_IDLE, on rx_valid_i:
  - If pending == 8, go to W_DROP.
  - Otherwise write the halfword at hw_idx 0 and go to W_FRAME.
  - A single-halfword frame (rx_last_i in W_IDLE) is handled as the commit rules below.
- Writes: mem_ena_o = mem_wea_o = rx_valid_i & accepted; same-cycle combinational, zero latency; hw_idx increments per write.
- Frame end: on rx_last_i with no error, commit.
  - Store length = 2*hw_idx_of_last + (rx_odd_i ? 1 : 2) in the 12-bit per-slot length register.
  - Advance the write slot modulo 8; pending += 1; return to W_IDLE.
- Error end: rx_err_i on last → discard; slot and pointer unchanged; drop_cnt += 1.
- Oversize: a 1025th halfword (hw_idx wraps) → go to W_DROP; no further writes.
- W_DROP: ignore input until rx_last_i, then drop_cnt += 1 once per frame, return to W_IDLE.
- Read FSM states: R_IDLE, R_READ.
  - R_IDLE → R_READ when pending > 0; load beats = ceil(len/8).
  - R_READ issues mem_enb_o with qw_idx 0..beats-1 only while (skid occupancy + in-flight) < 2, so the read side never stalls the RAM.
  - Returned data enters a 2-entry skid FIFO that drives m_t*.
  - Each beat carries tkeep = 8'hFF, except the last beat: tkeep = (len mod 8 == 0) ? 8'hFF : (8'hFF >> (8 - len mod 8)); tlast = 1 on the last beat.
- Slot release: when the tlast beat handshakes, pending -= 1, advance the read slot, return to R_IDLE.
  - The next frame's reads may start the cycle after the release.
- A same-cycle commit and release leave pending unchanged.
- m_tvalid_o must not drop without a handshake; m_tdata_o, m_tkeep_o and m_tlast_o stay stable while m_tvalid_o & !m_tready_i.
- Reset mid-frame: the partial frame is lost silently; not counted as a drop.

Optional Feature:
- Macro RX_CRC_STRIP_EN.
- Defined:
  - Committed length = raw length - 4 (FCS removed from the stream).
  - Frames with raw length ≤ 4 are dropped and counted.
  - The stripped bytes are still written to RAM.
- Undefined: length = raw byte count, FCS included.

Test Plan:
- Single 64-byte frame (32 halfwords, even, no error):
  - Port A writes addr 0..31.
  - Stream gives 8 beats, tkeep FF, tlast on beat 8.
  - frames_pending goes 1 then 0.
- 61-byte frame (31 halfwords, rx_odd_i on last) → 8 beats; last beat tkeep = 8'h1F.
- Frame ending with rx_err_i:
  - No stream output; drop_cnt = 1.
  - The next good frame is still written to slot 0 (addra[12:10] = 0).
- Nine back-to-back 60-byte frames with m_tready_i = 0 → frames_pending = 8, 9th frame dropped (drop_cnt = 1); after tready = 1, exactly 8 frames are emitted in order.
- 1100-halfword frame → no writes after hw 1023, dropped, drop_cnt += 1; the write pointer is unchanged.
- m_tready_i toggled 1010… during a 128-byte frame:
  - All 16 beats emitted, none duplicated or lost, data matches.
  - mem_enb_o never asserted with the skid FIFO full.
